// File: rtl/sdm_rx_dec_if.sv
// Sample bus of sdm_rx_dec: full/pop/rdata toggle handshake from sdm_rx
// and the dout/dvalid/dready result register toward the consumer.
interface sdm_rx_dec_if #(
  parameter int DMSB = 3
) ();
  logic            full;
  logic            pop;
  logic [DMSB:0]   rdata;
  logic [DMSB:0]   dout;
  logic            dvalid;
  logic            dready;

  modport master (
    output full, rdata, dready,
    input  pop, dout, dvalid
  );

  modport slave (
    input  full, rdata, dready,
    output pop, dout, dvalid
  );
endinterface

// File: rtl/sdm_rx_dec.sv
// Decimating averager after sdm_rx: averages 2^LOG2N signed samples per output.
// Optional macro SDM_RX_DEC_ROUND_EN selects round-half-up with saturation.
module sdm_rx_dec #(
  parameter int DMSB  = 3,
  parameter int LOG2N = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             setn,
  input  logic             clear,
  sdm_rx_dec_if.slave      bus,
  output logic             ovf,
  output logic [LOG2N-1:0] cnt,
  output logic [1:0]       xst
);

  localparam int AW = DMSB + 1 + LOG2N;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAKE = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    full_q;
  logic                    pop_q, pop_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic [LOG2N-1:0]        cnt_q, cnt_d;
  logic [DMSB:0]           dout_q, dout_d;
  logic                    dvalid_q, dvalid_d;
  logic                    ovf_q, ovf_d;

  logic                    capture;
  logic                    wrap;
  logic signed [AW-1:0]    sum;
  logic [DMSB:0]           result;

  assign capture = (state_q == IDLE) && setn && full_q && !clear;
  assign wrap    = (cnt_q == '1);
  assign sum     = acc_q + {{LOG2N{bus.rdata[DMSB]}}, bus.rdata};

`ifdef SDM_RX_DEC_ROUND_EN
  localparam logic signed [AW:0] HALF = (AW+1)'(1) << (LOG2N - 1);
  localparam logic signed [AW:0] MAXV = (AW+1)'((2 ** DMSB) - 1);
  localparam logic signed [AW:0] MINV = -MAXV - (AW+1)'(1);
  logic signed [AW:0] rsum, rshift;

  always_comb begin
    rsum   = {sum[AW-1], sum} + HALF;
    rshift = rsum >>> LOG2N;
    if (rshift > MAXV)      result = MAXV[DMSB:0];
    else if (rshift < MINV) result = MINV[DMSB:0];
    else                    result = rshift[DMSB:0];
  end
`else
  // Bit slice of the sum equals the arithmetic (floor) shift truncated to DMSB+1.
  assign result = sum[LOG2N +: DMSB+1];
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (!setn) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (capture) state_d = TAKE;
        TAKE:    state_d = WAIT;
        WAIT:    if (!full_q) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM / register outputs
  always_comb begin
    xst        = state_q;
    bus.pop    = pop_q;
    bus.dout   = dout_q;
    bus.dvalid = dvalid_q;
    ovf        = ovf_q;
    cnt        = cnt_q;
  end

  always_comb begin
    pop_d    = pop_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    ovf_d    = ovf_q;

    if (clear || !setn) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (capture) begin
      pop_d = ~pop_q;
      cnt_d = cnt_q + LOG2N'(1);
      acc_d = wrap ? '0 : sum;
    end

    // A fresh result takes precedence over the consumer's handshake.
    if (clear) begin
      dvalid_d = 1'b0;
      ovf_d    = 1'b0;
    end else if (capture && wrap) begin
      if (!dvalid_q || bus.dready) begin
        dout_d   = result;
        dvalid_d = 1'b1;
      end else begin
        ovf_d    = 1'b1;
      end
    end else if (dvalid_q && bus.dready) begin
      dvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q   <= 1'b0;
      pop_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      full_q   <= bus.full;
      pop_q    <= pop_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_sdm_rx_dec.sv
// Self-checking bench for sdm_rx_dec: directed scenarios plus randomized blocks
// checked against an arithmetic average model with a one-deep output slot.
module tb_sdm_rx_dec;
  localparam int DMSB  = 3;
  localparam int LOG2N = 2;
  localparam int N     = 1 << LOG2N;

  logic             clk = 1'b0;
  logic             rst;
  logic             setn;
  logic             clear;
  logic             ovf;
  logic [LOG2N-1:0] cnt;
  logic [1:0]       xst;

  int vectors = 0;
  int errors  = 0;
  int exp_dout = 0;

  sdm_rx_dec_if #(.DMSB(DMSB)) bus ();

  sdm_rx_dec #(.DMSB(DMSB), .LOG2N(LOG2N)) dut (
    .clk   (clk),
    .rst   (rst),
    .setn  (setn),
    .clear (clear),
    .bus   (bus),
    .ovf   (ovf),
    .cnt   (cnt),
    .xst   (xst)
  );

  always #5 clk = ~clk;

  function automatic int floor_div(int a, int n);
    int q;
    q = a / n;
    if ((a % n != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int ref_avg(int s);
    int q;
`ifdef SDM_RX_DEC_ROUND_EN
    int hi, lo;
    hi = (1 << DMSB) - 1;
    lo = -(1 << DMSB);
    q = floor_div(s + N / 2, N);
    if (q > hi) q = hi;
    if (q < lo) q = lo;
`else
    q = floor_div(s, N);
`endif
    return q;
  endfunction

  function automatic int sdout();
    return int'($signed(bus.dout));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behaves like sdm_rx: present a sample, hold full until pop toggles.
  task automatic send_sample(input int v, output int lat);
    logic p0;
    repeat (2) tick();
    bus.rdata = (DMSB+1)'(v);
    bus.full  = 1'b1;
    p0  = bus.pop;
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.pop !== p0) begin
        lat = i;
        break;
      end
    end
    bus.full = 1'b0;
    vectors++;
    if (lat < 0) begin
      errors++;
      $display("FAIL pop_timeout: no pop toggle for sample %0d within 10 cycles", v);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; setn = 1'b1; clear = 1'b0;
    bus.full = 1'b0; bus.rdata = '0; bus.dready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    vectors++;
    if ({bus.pop, bus.dout, bus.dvalid, ovf, cnt, xst} !== '0) begin
      errors++;
      $display("FAIL reset_state: pop=%b dout=%0d dvalid=%b ovf=%b cnt=%0d xst=%0d expected all 0",
               bus.pop, bus.dout, bus.dvalid, ovf, cnt, xst);
    end
  endtask

  task automatic test_average(input int s[4]);
    int lat, sum, exp;
    sum = 0;
    do_clear();
    bus.dready = 1'b1;
    for (int k = 0; k < N; k++) begin
      send_sample(s[k], lat);
      sum += s[k];
      vectors++;
      if (lat != 1) begin
        errors++;
        $display("FAIL pop_latency: got %0d extra edges expected 1", lat);
      end
      vectors++;
      if (cnt !== LOG2N'((k + 1) % N)) begin
        errors++;
        $display("FAIL avg_cnt: got %0d expected %0d", cnt, (k + 1) % N);
      end
    end
    exp = ref_avg(sum);
    exp_dout = exp;
    vectors++;
    if (bus.dvalid !== 1'b1 || sdout() != exp) begin
      errors++;
      $display("FAIL avg_result: dvalid=%b dout=%0d expected dvalid=1 dout=%0d", bus.dvalid, sdout(), exp);
    end
    tick();
    vectors++;
    if (bus.dvalid !== 1'b0 || sdout() != exp) begin
      errors++;
      $display("FAIL avg_dvalid_pulse: dvalid=%b dout=%0d expected dvalid=0 dout=%0d", bus.dvalid, sdout(), exp);
    end
  endtask

  task automatic test_full_held();
    int n;
    logic p0;
    do_clear();
    repeat (2) tick();
    bus.rdata = 4'd5;
    bus.full  = 1'b1;
    p0 = bus.pop;
    n  = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.pop !== p0) begin
        n++;
        p0 = bus.pop;
      end
    end
    vectors++;
    if (xst !== 2'd2) begin
      errors++;
      $display("FAIL held_wait: xst=%0d expected 2", xst);
    end
    bus.full = 1'b0;
    repeat (3) tick();
    vectors++;
    if (n != 1 || cnt !== LOG2N'(1) || xst !== 2'd0) begin
      errors++;
      $display("FAIL held_single: toggles=%0d cnt=%0d xst=%0d expected 1,1,0", n, cnt, xst);
    end
    do_clear();
  endtask

  task automatic test_overflow();
    int lat;
    do_clear();
    bus.dready = 1'b0;
    for (int k = 0; k < N; k++) send_sample(5, lat);
    exp_dout = ref_avg(5 * N);
    vectors++;
    if (sdout() != exp_dout || bus.dvalid !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_first: dout=%0d dvalid=%b ovf=%b expected %0d,1,0", sdout(), bus.dvalid, ovf, exp_dout);
    end
    for (int k = 0; k < N; k++) send_sample(-3, lat);
    vectors++;
    if (sdout() != exp_dout || bus.dvalid !== 1'b1 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drop: dout=%0d dvalid=%b ovf=%b expected %0d,1,1", sdout(), bus.dvalid, ovf, exp_dout);
    end
    do_clear();
    vectors++;
    if (ovf !== 1'b0 || bus.dvalid !== 1'b0 || cnt !== '0 || sdout() != exp_dout) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b dvalid=%b cnt=%0d dout=%0d expected 0,0,0,%0d",
               ovf, bus.dvalid, cnt, sdout(), exp_dout);
    end
    bus.dready = 1'b1;
  endtask

  task automatic test_setn();
    int lat;
    do_clear();
    bus.dready = 1'b1;
    send_sample(3, lat);
    send_sample(3, lat);
    setn = 1'b0;
    repeat (3) tick();
    vectors++;
    if (cnt !== '0 || xst !== 2'd0 || sdout() != exp_dout) begin
      errors++;
      $display("FAIL setn_hold: cnt=%0d xst=%0d dout=%0d expected 0,0,%0d", cnt, xst, sdout(), exp_dout);
    end
    setn = 1'b1;
    for (int k = 0; k < N; k++) send_sample(7, lat);
    exp_dout = ref_avg(7 * N);
    vectors++;
    if (sdout() != exp_dout || bus.dvalid !== 1'b1 || cnt !== '0) begin
      errors++;
      $display("FAIL setn_fresh: dout=%0d dvalid=%b cnt=%0d expected %0d,1,0", sdout(), bus.dvalid, cnt, exp_dout);
    end
  endtask

  task automatic test_random();
    int lat, v, sum;
    bit d, pend, ovf_m, ok;
    int dout_m;
    do_clear();
    pend = 1'b0; ovf_m = 1'b0; dout_m = exp_dout;
    for (int b = 0; b < 24; b++) begin
      d = ($urandom_range(0, 2) != 0);
      bus.dready = d;
      if (d) pend = 1'b0;
      sum = 0;
      for (int k = 0; k < N; k++) begin
        v = int'($urandom_range(0, 15)) - 8;
        send_sample(v, lat);
        sum += v;
        vectors++;
        if (cnt !== LOG2N'((k + 1) % N)) begin
          errors++;
          $display("FAIL rand_cnt: block %0d got %0d expected %0d", b, cnt, (k + 1) % N);
        end
      end
      if (!pend) begin
        dout_m = ref_avg(sum);
        pend = 1'b1;
      end else begin
        ovf_m = 1'b1;
      end
      vectors++;
      if (sdout() != dout_m || bus.dvalid !== 1'b1 || ovf !== ovf_m) begin
        errors++;
        $display("FAIL rand_block: block %0d dout=%0d dvalid=%b ovf=%b expected %0d,1,%b",
                 b, sdout(), bus.dvalid, ovf, dout_m, ovf_m);
      end
      if (d) begin
        tick();
        pend = 1'b0;
        ok = (bus.dvalid === 1'b0);
        vectors++;
        if (!ok) begin
          errors++;
          $display("FAIL rand_consume: block %0d dvalid=%b expected 0", b, bus.dvalid);
        end
      end
    end
    exp_dout = dout_m;
  endtask

  task automatic test_rst_mid();
    int lat;
    bit seen;
    do_clear();
    bus.dready = 1'b0;
    for (int k = 0; k < N; k++) send_sample(6, lat);
    if (bus.pop === 1'b1) send_sample(1, lat);
    repeat (2) tick();
    bus.rdata = 4'd2;
    bus.full  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (xst === 2'd2) begin
        seen = 1'b1;
        break;
      end
    end
    vectors++;
    if (!seen || bus.pop !== 1'b1 || bus.dvalid !== 1'b1) begin
      errors++;
      $display("FAIL rst_setup: reached_wait=%b pop=%b dvalid=%b expected 1,1,1", seen, bus.pop, bus.dvalid);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus.pop, bus.dout, bus.dvalid, ovf, cnt, xst} !== '0) begin
      errors++;
      $display("FAIL rst_async: pop=%b dout=%0d dvalid=%b ovf=%b cnt=%0d xst=%0d expected all 0",
               bus.pop, bus.dout, bus.dvalid, ovf, cnt, xst);
    end
    bus.full = 1'b0;
    tick();
    rst = 1'b0;
    bus.dready = 1'b1;
    send_sample(3, lat);
    vectors++;
    if (lat != 1 || bus.pop !== 1'b1 || cnt !== LOG2N'(1)) begin
      errors++;
      $display("FAIL rst_resume: latency=%0d pop=%b cnt=%0d expected 1,1,1", lat, bus.pop, cnt);
    end
  endtask

  initial begin
    int s[4];
    test_reset();
    s = '{1, 2, 3, 4};
    test_average(s);
    s = '{-1, -1, -1, -2};
    test_average(s);
    s = '{7, 7, 7, 7};
    test_average(s);
    s = '{-8, -8, -8, -8};
    test_average(s);
    test_full_held();
    test_overflow();
    test_setn();
    test_random();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/sdm_rx_dec.md
Name: sdm_rx_dec

Overview:
- Decimating averager directly downstream of sdm_rx.
- Drains sdm_rx samples through its full/pop toggle handshake and accumulates 2^LOG2N signed samples.
- Emits one averaged sample per block on a valid/ready output register.
- Feeds the codebase's post-demodulation consumers and reduces the sample rate by 2^LOG2N.

Parameters:
DMSB, 3, MSB of signed input sample and of signed output sample
LOG2N, 2, log2 of samples averaged per output (1..6)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  asynchronous active-high reset
setn  input  1  synchronous enable; 0 returns FSM to IDLE, clears acc/cnt, holds pop
clear  input  1  synchronous clear of acc, cnt, dvalid, ovf (one-cycle pulse)
full  input  1  sdm_rx full flag: sample available when 1
pop  output  1  toggle to sdm_rx; each transition consumes one sample
rdata  input  DMSB+1  signed sample from sdm_rx, valid while full=1
dout  output  DMSB+1  signed averaged sample
dvalid  output  1  dout holds an unconsumed result
dready  input  1  consumer accepts dout when dvalid&dready at posedge
ovf  output  1  sticky: result dropped because dvalid was still 1
cnt  output  LOG2N  samples accumulated in current block
xst  output  2  FSM state: 0 IDLE, 1 TAKE, 2 WAIT

Behaviour:
- Reset (rst=1, async): pop=0, dout=0, dvalid=0, ovf=0, cnt=0, acc=0, xst=IDLE.
- full is registered once (full_q) before use; rdata is captured in the same cycle full_q is seen high.
- IDLE:
  - setn=1 and full_q=1 -> TAKE.
  - acc += sign-extended rdata; accumulator width DMSB+1+LOG2N, never overflows.
  - pop toggles on that edge.
- TAKE -> WAIT unconditionally (one cycle, lets sdm_rx see the pop edge).
- WAIT: stays until full_q=0, then -> IDLE. This prevents double-consuming a sample.
- cnt increments per capture and wraps at 2^LOG2N. On the capture that wraps cnt to 0:
  - result = (acc + rdata) >>> LOG2N (arithmetic shift, floor), truncated to DMSB+1 bits; always in range.
  - acc is reset to 0 in the same edge.
  - If dvalid=0 or dready=1 that cycle: dout <= result, dvalid <= 1.
  - Otherwise the result is dropped, dout is kept, and ovf <= 1.
- dvalid&dready with no new result: dvalid <= 0 next edge; dout holds its value.
- Latency: full rising -> pop toggle = 2 clk edges; last capture -> dvalid = 1 edge later.
- clear takes priority over capture in the same cycle. It clears acc, cnt, dvalid, ovf. It does not toggle pop and does not change xst.
- setn=0 mid-block: partial accumulation discarded, dout/ovf retained, next block starts fresh.
- rst mid-handshake: pop returns to 0. A parity mismatch with sdm_rx is resolved by the system reset, which resets both blocks together.
- Minimum throughput: one sample per 3 clk cycles plus the sdm_rx refill time.

Optional Feature:
SDM_RX_DEC_ROUND_EN
- Defined: result = (sum + 2^(LOG2N-1)) >>> LOG2N (round half toward +inf), then saturated to [-(2^DMSB), 2^DMSB-1].
- Undefined: plain floor shift as above; no saturation logic.

Test Plan:
- DMSB=3, LOG2N=2, rdata 1,2,3,4 across four full pulses, dready=1:
  - Four pop toggles.
  - dout=2, dvalid one cycle.
  - With SDM_RX_DEC_ROUND_EN: dout=3.
- rdata -1,-1,-1,-2:
  - dout=-2 (floor).
  - With ROUND_EN: dout=-1.
- full held high 20 cycles for one sample: exactly one pop toggle, cnt 0->1; xst stays WAIT until full drops.
- dready=0, eight samples of value 5:
  - First result dout=5, dvalid=1.
  - Second result dropped: ovf=1, dout still 5.
  - clear pulse -> ovf=0, dvalid=0.
- Two samples captured, then setn=0 for 3 cycles, then four samples of 7: dout=7 (partial block discarded), cnt=0 afterward.
- rst asserted while xst=WAIT: all outputs immediately 0, xst=IDLE. After release and a new full, normal capture resumes.
